// File: rtl/game_sim_pkg.sv
// Shared widths, defaults and the sequencer state type for the board-game move logic.
// tile_to_x maps a tile index to its pixel column with one constant multiply-add.
package game_sim_pkg;
   localparam int X_W              = 10;
   localparam int TILE_W           = 4;
   localparam int TILE_SPACING_DEF = 60;
   localparam int START_X_DEF      = 20;
   localparam int NUM_TILES_DEF    = 10;

   typedef enum logic [1:0] {S_IDLE, S_MOVE, S_WAIT, S_WIN} seq_state_t;

   function automatic logic [X_W-1:0] tile_to_x(input logic [TILE_W-1:0] tile,
                                                input int start_x, input int spacing);
      return X_W'(start_x + int'(tile) * spacing);
   endfunction
endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stability counter and rising-edge pulse for one raw button.
// The accepted level flips only after the synchronised input has disagreed with it long enough.
module btn_debounce #(
   parameter int CYCLES = 250000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   output logic press_o
);
   localparam int CW = $clog2(CYCLES + 1);

   logic          sync1_q, sync2_q, level_q, level_d, press_q;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CW'(CYCLES)) level_d = sync2_q;
         else                      cnt_d   = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         press_q <= level_d & ~level_q;
      end
   end

   assign press_o = press_q;
endmodule

// File: rtl/player_move_sequencer.sv
// Turn-based move generator: debounced step buttons move the current player toward the
// flag tile, one pos_valid strobe per move, then the turn passes on turn_done or timeout.
module player_move_sequencer
   import game_sim_pkg::*;
#(
   parameter int NUM_PLAYERS     = 2,
   parameter int NUM_STEPS       = 3,
   parameter int TILE_SPACING    = TILE_SPACING_DEF,
   parameter int START_X         = START_X_DEF,
   parameter int NUM_TILES       = NUM_TILES_DEF,
   parameter int OVERSHOOT_CLAMP = 0,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int TIMEOUT_CYCLES  = 1 << 24
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [NUM_STEPS-1:0]          btn_step_i,
   input  logic [NUM_PLAYERS-1:0]        turn_done_i,
   output logic [NUM_PLAYERS*X_W-1:0]    pos_x_o,
   output logic [NUM_PLAYERS-1:0]        pos_valid_o,
   output logic [NUM_PLAYERS*TILE_W-1:0] tile_idx_o,
   output logic [1:0]                    cur_player_o,
   output logic                          move_reject_o,
   output logic                          timeout_err_o,
   output logic                          winner_valid_o,
   output logic [1:0]                    winner_id_o
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TILE_W:0] LAST_T = (TILE_W+1)'(NUM_TILES);

   logic [NUM_STEPS-1:0] press;

   generate
      for (genvar k = 0; k < NUM_STEPS; k++) begin : g_btn
         btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .btn_i   (btn_step_i[k]),
            .press_o (press[k])
         );
      end
   endgenerate

   seq_state_t                          state_q;
   logic [1:0]                          cur_q, win_id_q;
   logic [NUM_PLAYERS-1:0][TILE_W-1:0]  tile_q;
   logic [NUM_PLAYERS-1:0][X_W-1:0]     x_q;
   logic [TILE_W-1:0]                   new_tile_q;
   logic [TW-1:0]                       wait_q;
   logic [NUM_PLAYERS-1:0]              pos_valid_q;
   logic                                move_reject_q, timeout_q, win_q;

   logic [TILE_W-1:0] cur_tile;
   logic              cur_done, timeout_hit;
   logic [TILE_W:0]   step_n, t_sum;
   logic [1:0]        next_player;

   // Player selection by compare loop keeps the 2-bit cur index legal for any player count.
   always_comb begin
      cur_tile = '0;
      cur_done = 1'b0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         if (cur_q == 2'(p)) begin
            cur_tile = tile_q[p];
            cur_done = turn_done_i[p];
         end
      end
      step_n = '0;
      for (int k = NUM_STEPS - 1; k >= 0; k--) begin
         if (press[k]) step_n = (TILE_W+1)'(k + 1);
      end
      t_sum       = {1'b0, cur_tile} + step_n;
      next_player = (cur_q == 2'(NUM_PLAYERS - 1)) ? 2'd0 : cur_q + 2'd1;
      timeout_hit = (wait_q == TW'(TIMEOUT_CYCLES - 1));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= S_IDLE;
         cur_q         <= 2'd0;
         win_id_q      <= 2'd0;
         new_tile_q    <= '0;
         wait_q        <= '0;
         pos_valid_q   <= '0;
         move_reject_q <= 1'b0;
         timeout_q     <= 1'b0;
         win_q         <= 1'b0;
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            tile_q[p] <= '0;
            x_q[p]    <= X_W'(START_X);
         end
      end else begin
         pos_valid_q   <= '0;
         move_reject_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (|press) begin
                  if (t_sum <= LAST_T || OVERSHOOT_CLAMP != 0) begin
                     new_tile_q <= (t_sum > LAST_T) ? TILE_W'(NUM_TILES) : t_sum[TILE_W-1:0];
                     state_q    <= S_MOVE;
                  end else begin
                     move_reject_q <= 1'b1;
                     cur_q         <= next_player;
                  end
               end
            end
            S_MOVE: begin
               for (int p = 0; p < NUM_PLAYERS; p++) begin
                  if (cur_q == 2'(p)) begin
                     tile_q[p]      <= new_tile_q;
                     x_q[p]         <= tile_to_x(new_tile_q, START_X, TILE_SPACING);
                     pos_valid_q[p] <= 1'b1;
                  end
               end
               wait_q  <= '0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               // turn_done takes priority over a coincident timeout.
               if (cur_done || timeout_hit) begin
                  if (!cur_done) timeout_q <= 1'b1;
                  if (cur_tile == TILE_W'(NUM_TILES)) begin
                     state_q  <= S_WIN;
                     win_q    <= 1'b1;
                     win_id_q <= cur_q;
                  end else begin
                     cur_q   <= next_player;
                     state_q <= S_IDLE;
                  end
               end else begin
                  wait_q <= wait_q + 1'b1;
               end
            end
            S_WIN: begin
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign pos_x_o        = x_q;
   assign tile_idx_o     = tile_q;
   assign pos_valid_o    = pos_valid_q;
   assign cur_player_o   = cur_q;
   assign move_reject_o  = move_reject_q;
   assign timeout_err_o  = timeout_q;
   assign winner_valid_o = win_q;
   assign winner_id_o    = win_id_q;
endmodule

// File: tb/tb_player_move_sequencer.sv
// Directed and randomized turns on a 2-player reject-mode and a 3-player clamp-mode
// sequencer, compared against a tile-count model of the game rules.
module tb_player_move_sequencer;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [2:0]  btn_a, btn_b;
   logic [1:0]  done_a;
   logic [2:0]  done_b;
   logic [19:0] px_a;
   logic [29:0] px_b;
   logic [1:0]  pv_a;
   logic [2:0]  pv_b;
   logic [7:0]  ti_a;
   logic [11:0] ti_b;
   logic [1:0]  cur_a, cur_b, wid_a, wid_b;
   logic        rej_a, rej_b, to_a, to_b, wv_a, wv_b;

   int checks = 0;
   int failures = 0;

   // Game model: tile per player, whose turn, sticky timeout, winner.
   int m_tile[3];
   int m_cur, m_to, m_win, m_wid, m_np, m_clamp;

   player_move_sequencer #(.NUM_PLAYERS(2), .OVERSHOOT_CLAMP(0),
                           .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(50)) dut_a (
      .clk_i(clk), .rst_i(rst), .btn_step_i(btn_a), .turn_done_i(done_a),
      .pos_x_o(px_a), .pos_valid_o(pv_a), .tile_idx_o(ti_a), .cur_player_o(cur_a),
      .move_reject_o(rej_a), .timeout_err_o(to_a), .winner_valid_o(wv_a), .winner_id_o(wid_a));

   player_move_sequencer #(.NUM_PLAYERS(3), .OVERSHOOT_CLAMP(1),
                           .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(50)) dut_b (
      .clk_i(clk), .rst_i(rst), .btn_step_i(btn_b), .turn_done_i(done_b),
      .pos_x_o(px_b), .pos_valid_o(pv_b), .tile_idx_o(ti_b), .cur_player_o(cur_b),
      .move_reject_o(rej_b), .timeout_err_o(to_b), .winner_valid_o(wv_b), .winner_id_o(wid_b));

   function automatic logic [31:0] gx(input int d, input int p);
      if (d == 0) return 32'(px_a[p*10 +: 10]);
      return 32'(px_b[p*10 +: 10]);
   endfunction
   function automatic logic [31:0] gti(input int d, input int p);
      if (d == 0) return 32'(ti_a[p*4 +: 4]);
      return 32'(ti_b[p*4 +: 4]);
   endfunction
   function automatic logic [31:0] gpv(input int d);
      return (d == 0) ? 32'(pv_a) : 32'(pv_b);
   endfunction
   function automatic logic [31:0] gcur(input int d);
      return (d == 0) ? 32'(cur_a) : 32'(cur_b);
   endfunction
   function automatic logic [31:0] gwid(input int d);
      return (d == 0) ? 32'(wid_a) : 32'(wid_b);
   endfunction
   function automatic logic grej(input int d);
      return (d == 0) ? rej_a : rej_b;
   endfunction
   function automatic logic gto(input int d);
      return (d == 0) ? to_a : to_b;
   endfunction
   function automatic logic gwv(input int d);
      return (d == 0) ? wv_a : wv_b;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_btn(input int d, input int k, input logic v);
      if (d == 0) btn_a[k] = v;
      else        btn_b[k] = v;
   endtask
   task automatic set_done(input int d, input int p, input logic v);
      if (d == 0) done_a[p] = v;
      else        done_b[p] = v;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      btn_a = '0; btn_b = '0; done_a = '0; done_b = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic model_reset(input int np, input int clamp);
      for (int p = 0; p < 3; p++) m_tile[p] = 0;
      m_cur = 0; m_to = 0; m_win = 0; m_wid = 0; m_np = np; m_clamp = clamp;
   endtask

   task automatic chk_reset(input int d, input int np);
      for (int p = 0; p < np; p++) begin
         chk("rst_pos_x", gx(d, p), 20);
         chk("rst_tile", gti(d, p), 0);
      end
      chk("rst_pos_valid", gpv(d), 0);
      chk("rst_cur", gcur(d), 0);
      chk("rst_reject", 32'(grej(d)), 0);
      chk("rst_timeout", 32'(gto(d)), 0);
      chk("rst_winner_valid", 32'(gwv(d)), 0);
      chk("rst_winner_id", gwid(d), 0);
   endtask

   // Hold button k, watch 30 cycles for strobes, release at cycle 20.
   task automatic step(input int d, input int k, output int moved, output int since_pv);
      int t, exp_tile, pv_cnt, rej_cnt, lat, pv_bits, old_x;
      t = m_tile[m_cur] + k + 1;
      old_x = int'(gx(d, m_cur));
      pv_cnt = 0; rej_cnt = 0; lat = -1; pv_bits = 0; moved = 0;
      set_btn(d, k, 1'b1);
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (gpv(d) != 0) begin
            pv_cnt++;
            if (lat < 0) begin lat = i; pv_bits = int'(gpv(d)); end
         end
         if (grej(d)) rej_cnt++;
         if (i == 20) set_btn(d, k, 1'b0);
      end
      since_pv = (lat >= 0) ? 30 - lat : 0;
      if (m_win != 0) begin
         chk("win_press_pv", pv_cnt, 0);
         chk("win_press_rej", rej_cnt, 0);
         chk("win_hold_valid", 32'(gwv(d)), 1);
         chk("win_hold_id", gwid(d), m_wid);
      end else if (t <= 10 || m_clamp != 0) begin
         exp_tile = (t > 10) ? 10 : t;
         chk("move_pv_count", pv_cnt, 1);
         chk("move_pv_latency", lat, 9);
         chk("move_pv_player", pv_bits, 1 << m_cur);
         chk("move_reject", rej_cnt, 0);
         chk("move_pos_x", gx(d, m_cur), 20 + 60 * exp_tile);
         chk("move_tile", gti(d, m_cur), exp_tile);
         m_tile[m_cur] = exp_tile;
         moved = 1;
      end else begin
         chk("reject_count", rej_cnt, 1);
         chk("reject_pv", pv_cnt, 0);
         chk("reject_pos_x", gx(d, m_cur), old_x);
         m_cur = (m_cur + 1) % m_np;
         chk("reject_cur", gcur(d), m_cur);
      end
   endtask

   // mode 0: turn_done (after an ignored foreign turn_done); mode 1: let it time out.
   task automatic finish_turn(input int d, input int mode, input int since_pv);
      int other;
      if (mode == 0) begin
         other = (m_cur + 1) % m_np;
         set_done(d, other, 1'b1);
         @(negedge clk);
         set_done(d, other, 1'b0);
         @(negedge clk);
         chk("foreign_done_ignored", gcur(d), m_cur);
         set_done(d, m_cur, 1'b1);
         @(negedge clk);
         set_done(d, m_cur, 1'b0);
      end else begin
         repeat (60 - since_pv) @(negedge clk);
         m_to = 1;
      end
      if (m_tile[m_cur] == 10) begin
         m_win = 1; m_wid = m_cur;
      end else begin
         m_cur = (m_cur + 1) % m_np;
      end
      chk("turn_cur", gcur(d), m_cur);
      chk("turn_timeout_err", 32'(gto(d)), m_to);
      chk("turn_winner_valid", 32'(gwv(d)), m_win);
      if (m_win != 0) chk("turn_winner_id", gwid(d), m_wid);
      if (mode == 0 && m_win == 0) begin
         set_done(d, m_cur, 1'b1);
         @(negedge clk);
         set_done(d, m_cur, 1'b0);
         @(negedge clk);
         chk("idle_done_ignored", gcur(d), m_cur);
      end
   endtask

   initial begin
      int mv, sp, lat, n, got;
      rst = 1'b1;
      btn_a = '0; btn_b = '0; done_a = '0; done_b = '0;
      repeat (2) @(negedge clk);
      chk_reset(0, 2);
      chk_reset(1, 3);
      rst = 1'b0;
      @(negedge clk);

      // First move: step 2 takes player 0 to tile 2 (x=140).
      model_reset(2, 0);
      step(0, 1, mv, sp);
      finish_turn(0, 0, sp);

      // Two-cycle glitch must not register.
      btn_a[0] = 1'b1;
      repeat (2) @(negedge clk);
      btn_a[0] = 1'b0;
      n = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (pv_a != 0 || rej_a) n++;
      end
      chk("glitch_no_move", n, 0);
      // Three-cycle bounce then stable high: exactly one move.
      btn_a[0] = 1'b1;
      repeat (3) @(negedge clk);
      btn_a[0] = 1'b0;
      n = 0;
      repeat (2) begin
         @(negedge clk);
         if (pv_a != 0) n++;
      end
      chk("bounce_no_early_move", n, 0);
      step(0, 0, mv, sp);
      finish_turn(0, 0, sp);

      // Timeout exactly 50 cycles after pos_valid, foreign turn_done ignored meanwhile.
      do_reset();
      model_reset(2, 0);
      btn_a[0] = 1'b1;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (lat < 0 && pv_a != 0) lat = i;
      end
      chk("to_pv_latency", lat, 9);
      n = 0; got = 0;
      for (int i = 21 - lat; i <= 80 && got == 0; i++) begin
         @(negedge clk);
         if (i == 25) btn_a[0] = 1'b0;
         if (i == 30) done_a[1] = 1'b1;
         if (i == 31) done_a[1] = 1'b0;
         if (to_a) begin n = i; got = 1; end
      end
      chk("timeout_cycle", n, 50);
      m_tile[0] = 1; m_to = 1; m_cur = 1;
      chk("timeout_cur", cur_a, m_cur);
      repeat (10) @(negedge clk);

      // Reject mode: player 0 reaches tile 9, then step 3 overshoots.
      do_reset();
      model_reset(2, 0);
      for (int r = 0; r < 3; r++) begin
         step(0, 2, mv, sp); finish_turn(0, 0, sp);
         step(0, 0, mv, sp); finish_turn(0, 0, sp);
      end
      chk("pre_reject_x", gx(0, 0), 560);
      step(0, 2, mv, sp);

      // Clamp mode, 3 players: rotation 0,1,2,0 then clamp to the flag and win.
      do_reset();
      model_reset(3, 1);
      chk("rot_cur0", cur_b, 0);
      step(1, 2, mv, sp); finish_turn(1, 0, sp);
      chk("rot_cur1", cur_b, 1);
      step(1, 0, mv, sp); finish_turn(1, 0, sp);
      chk("rot_cur2", cur_b, 2);
      step(1, 0, mv, sp); finish_turn(1, 0, sp);
      chk("rot_cur3", cur_b, 0);
      for (int r = 0; r < 2; r++) begin
         step(1, 2, mv, sp); finish_turn(1, 0, sp);
         step(1, 0, mv, sp); finish_turn(1, 0, sp);
         step(1, 0, mv, sp); finish_turn(1, 0, sp);
      end
      step(1, 2, mv, sp);
      chk("clamp_x", gx(1, 0), 620);
      finish_turn(1, 0, sp);
      step(1, 1, mv, sp);

      // Reset asserted while waiting for turn_done.
      do_reset();
      model_reset(3, 1);
      step(1, 0, mv, sp);
      rst = 1'b1;
      #1;
      chk_reset(1, 3);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Randomized games on both configurations.
      for (int d = 0; d < 2; d++) begin
         do_reset();
         model_reset(d == 0 ? 2 : 3, d);
         for (int it = 0; it < 30; it++) begin
            step(d, int'($urandom_range(0, 2)), mv, sp);
            if (mv != 0) finish_turn(d, ($urandom_range(0, 3) == 0) ? 1 : 0, sp);
            if (m_win != 0) begin
               step(d, int'($urandom_range(0, 2)), mv, sp);
               do_reset();
               model_reset(d == 0 ? 2 : 3, d);
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
